// File: rtl/char_scroll_display_if.sv
// char_scroll_display_if: mode/direction/pause controls, message write port and display outputs.
interface char_scroll_display_if #(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_LEN = 8
);
   localparam int AW = $clog2(MSG_LEN);
   logic fr_mode;
   logic fr_dir;
   logic fr_pause;
   logic fr_wr_en;
   logic [AW-1:0] fr_wr_addr;
   logic [2:0] fr_wr_char;
   logic [NUM_DIGITS*8-1:0] to_HEX;
   logic to_wrap;
   logic [1:0] to_state;
   modport master (
      output fr_mode, fr_dir, fr_pause, fr_wr_en, fr_wr_addr, fr_wr_char,
      input to_HEX, to_wrap, to_state
   );
   modport slave (
      input fr_mode, fr_dir, fr_pause, fr_wr_en, fr_wr_addr, fr_wr_char,
      output to_HEX, to_wrap, to_state
   );
endinterface

// File: rtl/char_scroll_display.sv
// char_scroll_display: scrolling 7-segment message display with a writable character buffer.
// Define DP_MARKER_EN to light the DP of the digit showing msg[0].
module char_scroll_display #(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_LEN = 8,
   parameter int TICK_DIV = 25_000_000
) (
   input logic fr_CLOCK_50,
   input logic fr_reset,
   char_scroll_display_if.slave bus
);
   localparam int AW = $clog2(MSG_LEN);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);
   localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);
   localparam logic [63:0] SEG_ROM = {8'hFF, 8'h8C, 8'hC7, 8'h89, 8'hC0, 8'hF9, 8'h86, 8'hA1};
   typedef enum logic [1:0] {ST_STATIC = 2'b00, ST_SCROLL = 2'b01, ST_HOLD = 2'b10} state_t;
   state_t state, nxt;
   logic [AW-1:0] off, idx;
   logic [PW-1:0] pre;
   logic [2:0] msg [MSG_LEN];
   logic [NUM_DIGITS*8-1:0] hex, hex_d;
   logic [7:0] d;
   logic tick, wrap;
   always_comb begin
      nxt = !bus.fr_mode ? ST_STATIC : bus.fr_pause ? ST_HOLD : ST_SCROLL;
      tick = state == ST_SCROLL && pre == TOP;
   end
   // leftmost digit shows msg[off]; walk the buffer rightwards with wraparound
   always_comb begin
      idx = off;
      d = '1;
      hex_d = '1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         d = SEG_ROM[{msg[idx], 3'b000} +: 8];
`ifdef DP_MARKER_EN
         if (idx == '0) d[7] = 1'b0;
`endif
         hex_d[8*(NUM_DIGITS-1-j) +: 8] = d;
         idx = (idx == LAST) ? '0 : idx + 1'b1;
      end
   end
   always_ff @(posedge fr_CLOCK_50) begin
      if (fr_reset) begin
         state <= ST_STATIC;
         off <= '0;
         pre <= '0;
         wrap <= 1'b0;
         hex <= '1;
         for (int i = 0; i < MSG_LEN; i++) msg[i] <= 3'(i % 4);
      end else begin
         state <= nxt;
         wrap <= tick && (bus.fr_dir ? off == '0 : off == LAST);
         hex <= hex_d;
         if (state == ST_STATIC) begin
            off <= '0;
            pre <= '0;
         end else if (state == ST_SCROLL) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) off <= bus.fr_dir ? (off == '0 ? LAST : off - 1'b1) : (off == LAST ? '0 : off + 1'b1);
         end
         if (bus.fr_wr_en && 32'(bus.fr_wr_addr) < MSG_LEN) msg[bus.fr_wr_addr] <= bus.fr_wr_char;
      end
   end
   assign bus.to_HEX = hex;
   assign bus.to_wrap = wrap;
   assign bus.to_state = state;
endmodule

// File: tb/tb_char_scroll_display.sv
// tb_char_scroll_display: reference-model scoreboard plus directed checks for char_scroll_display.
module tb_char_scroll_display;
   localparam int ND = 4;
   localparam int ML = 6;
   localparam int TD = 4;
`ifdef DP_MARKER_EN
   localparam logic [31:0] HEX_RST = 32'h2186F9C0;
   localparam logic [31:0] HEX_RIGHT = 32'h8621_86F9;
   localparam logic [31:0] HEX_STATIC_WR = 32'h4789F9C0;
`else
   localparam logic [31:0] HEX_RST = 32'hA186F9C0;
   localparam logic [31:0] HEX_RIGHT = 32'h86A186F9;
   localparam logic [31:0] HEX_STATIC_WR = 32'hC789F9C0;
`endif
   localparam logic [31:0] HEX_SIMUL = 32'h89F9C0A1;
   typedef struct {
      logic [31:0] hex;
      logic wrap;
      logic [1:0] st;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int m_st, m_off, m_pre;
   int m_msg [ML];
   logic [7:0] segs [8] = '{8'hA1, 8'h86, 8'hF9, 8'hC0, 8'h89, 8'hC7, 8'h8C, 8'hFF};
   exp_t q[$];
   char_scroll_display_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();
   char_scroll_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
      .fr_CLOCK_50(clk),
      .fr_reset(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [31:0] render();
      logic [31:0] r;
      logic [7:0] b;
      int k;
      r = '1;
      for (int j = 0; j < ND; j++) begin
         k = (m_off + j) % ML;
         b = segs[m_msg[k]];
`ifdef DP_MARKER_EN
         if (k == 0) b[7] = 1'b0;
`endif
         r[8*(ND-1-j) +: 8] = b;
      end
      return r;
   endfunction
   task automatic model_step(output exp_t e);
      bit tick;
      if (rst) begin
         m_st = 0;
         m_off = 0;
         m_pre = 0;
         for (int i = 0; i < ML; i++) m_msg[i] = i % 4;
         e.hex = '1;
         e.wrap = 1'b0;
         e.st = 2'd0;
      end else begin
         tick = (m_st == 1) && (m_pre == TD - 1);
         e.hex = render();
         e.wrap = tick && (bus.fr_dir ? m_off == 0 : m_off == ML - 1);
         if (m_st == 0) begin
            m_off = 0;
            m_pre = 0;
         end else if (m_st == 1) begin
            if (tick) begin
               m_pre = 0;
               m_off = (m_off + (bus.fr_dir ? ML - 1 : 1)) % ML;
            end else m_pre++;
         end
         if (bus.fr_wr_en && int'(bus.fr_wr_addr) < ML) m_msg[bus.fr_wr_addr] = int'(bus.fr_wr_char);
         m_st = !bus.fr_mode ? 0 : bus.fr_pause ? 2 : 1;
         e.st = 2'(m_st);
      end
   endtask
   task automatic cyc();
      exp_t e, g;
      model_step(e);
      q.push_back(e);
      @(posedge clk);
      #1;
      g = q.pop_front();
      chk("hex", bus.to_HEX, g.hex);
      chk("wrap", 32'(bus.to_wrap), 32'(g.wrap));
      chk("state", 32'(bus.to_state), 32'(g.st));
   endtask
   task automatic wr(input int a, input int c);
      bus.fr_wr_en = 1'b1;
      bus.fr_wr_addr = 3'(a);
      bus.fr_wr_char = 3'(c);
   endtask
   initial begin
      int wraps, n;
      logic [31:0] h0;
      bus.fr_mode = 1'b0;
      bus.fr_dir = 1'b0;
      bus.fr_pause = 1'b0;
      bus.fr_wr_en = 1'b0;
      bus.fr_wr_addr = '0;
      bus.fr_wr_char = '0;
      cyc();
      cyc();
      chk("reset_hex", bus.to_HEX, 32'hFFFFFFFF);
      rst = 1'b0;
      cyc();
      chk("first_hex", bus.to_HEX, HEX_RST);
      chk("first_state", 32'(bus.to_state), 32'd0);
      bus.fr_mode = 1'b1;
      wraps = 0;
      for (int i = 0; i < 26; i++) begin
         cyc();
         wraps += int'(bus.to_wrap);
      end
      chk("left_wraps", 32'(wraps), 32'd1);
      chk("left_hex", bus.to_HEX, HEX_RST);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.fr_dir = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      chk("right_wrap", 32'(bus.to_wrap), 32'd1);
      cyc();
      chk("right_hex", bus.to_HEX, HEX_RIGHT);
      cyc();
      h0 = bus.to_HEX;
      bus.fr_pause = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      chk("hold_state", 32'(bus.to_state), 32'd2);
      chk("hold_hex", bus.to_HEX, h0);
      bus.fr_pause = 1'b0;
      n = 0;
      while (bus.to_HEX == h0 && n < 20) begin
         cyc();
         n++;
      end
      chk("resume_latency", 32'(n), 32'd3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.fr_dir = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      wr(1, 4);
      cyc();
      bus.fr_wr_en = 1'b0;
      cyc();
      chk("simul_hex", bus.to_HEX, HEX_SIMUL);
      bus.fr_mode = 1'b0;
      cyc();
      wr(7, 6);
      cyc();
      wr(0, 5);
      cyc();
      bus.fr_wr_en = 1'b0;
      cyc();
      chk("static_wr_hex", bus.to_HEX, HEX_STATIC_WR);
      bus.fr_mode = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      rst = 1'b1;
      wr(0, 6);
      cyc();
      chk("midrst_hex", bus.to_HEX, 32'hFFFFFFFF);
      rst = 1'b0;
      bus.fr_wr_en = 1'b0;
      bus.fr_mode = 1'b0;
      cyc();
      chk("midrst_buf", bus.to_HEX, HEX_RST);
      for (int i = 0; i < 300; i++) begin
         rst = $urandom_range(0, 49) == 0;
         bus.fr_mode = $urandom_range(0, 9) != 0;
         bus.fr_pause = $urandom_range(0, 5) == 0;
         if ($urandom_range(0, 15) == 0) bus.fr_dir = ~bus.fr_dir;
         bus.fr_wr_en = $urandom_range(0, 3) == 0;
         bus.fr_wr_addr = 3'($urandom_range(0, 7));
         bus.fr_wr_char = 3'($urandom_range(0, 7));
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
